// File: rtl/seg_scan_display.sv
// Six-digit multiplexed common-anode 7-segment driver for the clock core.
// Snapshots the time once per frame, inserts a blank cycle between digits, and blinks edited or alerted fields.
module seg_scan_display #(
  parameter logic [15:0] SCAN_DIV  = 16'd50000,
  parameter logic [23:0] BLINK_DIV = 24'd12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic [1:0] mode,
  input  logic       turn,
  input  logic       alert,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  logic [15:0] scan_cnt;
  logic [2:0]  idx;
  logic [23:0] blink_cnt;
  logic        blink_on;
  logic [23:0] snap;

  logic        scan_wrap;
  logic        blink_wrap;
  logic [3:0]  nib;
  logic        edit_mode;
  logic        in_blink;
  logic [5:0]  an_p0;
  logic [6:0]  seg_p0;
  logic        dp_p0;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign scan_wrap  = (scan_cnt == SCAN_DIV - 16'd1);
  assign blink_wrap = (blink_cnt == BLINK_DIV - 24'd1);

  // Scan, blink and frame-snapshot state
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt  <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      snap      <= '0;
    end else begin
      scan_cnt  <= scan_wrap ? 16'd0 : scan_cnt + 16'd1;
      blink_cnt <= blink_wrap ? 24'd0 : blink_cnt + 24'd1;
      if (blink_wrap)
        blink_on <= ~blink_on;
      if (scan_wrap) begin
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        if (idx == 3'd5)
          snap <= {hour, minute, second};
      end
    end
  end

  always_comb begin
    nib       = 4'd0;
    edit_mode = (mode == 2'd1) || (mode == 2'd2);
    in_blink  = 1'b0;
    an_p0     = 6'b111111;
    seg_p0    = 7'b1111111;
    dp_p0     = 1'b1;

    case (idx)
      3'd0:    nib = snap[23:20];
      3'd1:    nib = snap[19:16];
      3'd2:    nib = snap[15:12];
      3'd3:    nib = snap[11:8];
      3'd4:    nib = snap[7:4];
      default: nib = snap[3:0];
    endcase

    // Alert blinks every digit and takes precedence over the edit field
    if (alert)
      in_blink = 1'b1;
    else if (edit_mode)
      in_blink = turn ? (idx <= 3'd1) : ((idx == 3'd2) || (idx == 3'd3));

    seg_p0 = (!blink_on && in_blink) ? 7'b1111111 : decode(nib);

    if (scan_cnt != 16'd0) begin
      an_p0 = ~(6'b000001 << idx);
      dp_p0 = ~((blink_on && ((idx == 3'd1) || (idx == 3'd3))) ||
                ((idx == 3'd5) && (mode == 2'd2)));
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 6'b111111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_p0;
      seg <= seg_p0;
      dp  <= dp_p0;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: directed phases then random stimulus, scored against a time-based reference model.
module tb_seg_scan_display;

  localparam int S = 4;
  localparam int B = 64;
  localparam int PHASE_LEN = 200;
  localparam int NPHASE = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] hour, minute, second;
  logic [1:0] mode;
  logic       turn, alert;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  seg_scan_display #(.SCAN_DIV(16'd4), .BLINK_DIV(24'd64)) dut (
    .clk(clk), .reset(reset), .hour(hour), .minute(minute), .second(second),
    .mode(mode), .turn(turn), .alert(alert), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model state: elapsed cycles since reset and the displayed frame
  int          t;
  logic [23:0] frame;
  logic [6:0]  seg_tab [16];

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
  end

  function automatic exp_t model_out(int tt, logic [23:0] fr, int cyc);
    exp_t e;
    int   sc, id, nibv;
    bit   bon, blank, colon, alarm_dot;
    sc   = tt % S;
    id   = (tt / S) % 6;
    bon  = ((tt / B) % 2) == 0;
    nibv = (fr >> (4 * (5 - id))) & 24'hF;
    blank = 0;
    if (alert) blank = 1;
    else if (mode == 2'd1 || mode == 2'd2)
      blank = turn ? (id < 2) : (id == 2 || id == 3);
    e.seg = (!bon && blank) ? 7'b1111111 : seg_tab[nibv];
    colon     = bon && (id == 1 || id == 3);
    alarm_dot = (id == 5) && (mode == 2'd2);
    if (sc == 0) begin
      e.an = 6'b111111;
      e.dp = 1'b1;
    end else begin
      e.an = ~(6'd1 << id);
      e.dp = !(colon || alarm_dot);
    end
    e.cyc = cyc;
    return e;
  endfunction

  task automatic drive_phase(int ph);
    case (ph)
      0: begin hour = 8'h12; minute = 8'h34; second = 8'h56; mode = 2'd0; turn = 0; alert = 0; end
      1: begin second = 8'h57; end
      2: begin mode = 2'd1; turn = 1; end
      3: begin turn = 0; end
      4: begin alert = 1; end
      5: begin alert = 0; hour = 8'h1A; mode = 2'd2; end
      default: begin
        if ($urandom_range(0, 15) == 0) begin
          hour   = 8'($urandom);
          minute = 8'($urandom);
          second = 8'($urandom);
        end
        if ($urandom_range(0, 7) == 0) begin
          mode  = 2'($urandom);
          turn  = 1'($urandom);
          alert = ($urandom_range(0, 3) == 0);
        end
      end
    endcase
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    hour = 8'h00; minute = 8'h00; second = 8'h00;
    mode = 2'd0; turn = 1'b0; alert = 1'b0;
    t = 0;
    frame = 24'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      e.an = 6'b111111; e.seg = 7'b1111111; e.dp = 1'b1; e.cyc = -1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < NPHASE * PHASE_LEN; c++) begin
      if (c > 0) @(negedge clk);
      if (c % PHASE_LEN == 0) drive_phase(c / PHASE_LEN);
      else if (c / PHASE_LEN >= 6) drive_phase(c / PHASE_LEN);
      if (c == 5 * PHASE_LEN + 150 || (c / PHASE_LEN >= 6 && $urandom_range(0, 299) == 0))
        reset = 1'b1;
      else
        reset = 1'b0;
      if (reset) begin
        e.an = 6'b111111; e.seg = 7'b1111111; e.dp = 1'b1; e.cyc = c;
        exp_q.push_back(e);
        t = 0;
        frame = 24'h0;
      end else begin
        exp_q.push_back(model_out(t, frame, c));
        if ((t % S) == S - 1 && ((t / S) % 6) == 5)
          frame = {hour, minute, second};
        t++;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: every rising edge presents one registered output word
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
        fails++;
        if (fails <= 20)
          $display("FAIL out cyc=%0d: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                   e.cyc, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, queue=%0d", exp_q.size());
    $fatal(1, "timeout");
  end

endmodule
